i2c_eeprom_arbiter: RTL and testbench
=====================================

// Module: i2c_eeprom_arbiter
// PURPOSE
//  Shares one i2c_eeprom_top byte engine (level req / ack handshake) between NUM_REQ requesters.
//  Each requester posts a single-byte EEPROM read or write. The arbiter grants round-robin,
//  latches the command, drives the engine, returns read data and completion, and enforces
//  a post-write gap (EEPROM internal write cycle) plus a per-transfer timeout.
// PARAMETERS
//  NUM_REQ        2        number of requesters (2..4)
//  TIMEOUT_CYCLES 1000000  clk cycles in XFER without ack before abort (20-bit counter)
//  WR_GAP_CYCLES  250000   clk cycles idle after any completed or aborted write (tWR)
// PORTS
//  clk            in   1            system clock
//  reset          in   1            synchronous, active-high reset
//  req_valid      in   NUM_REQ      per-requester request; hold high until own done pulse
//  req_rd         in   NUM_REQ      1=read, 0=write; stable while req_valid
//  req_dev        in   NUM_REQ*7    7-bit device address, requester i at [7i+6:7i]
//  req_reg        in   NUM_REQ*8    register address, requester i at [8i+7:8i]
//  req_wdata      in   NUM_REQ*8    write byte, requester i at [8i+7:8i]
//  req_done       out  NUM_REQ      1-cycle pulse to granted requester on completion/abort
//  req_err        out  NUM_REQ      1-cycle pulse with req_done when aborted by timeout
//  rsp_rdata      out  8            read byte; valid from req_done until next read completes
//  busy           out  1            high in any state other than IDLE
//  i2c_write_req  out  1            to engine; level
//  i2c_read_req   out  1            to engine; level
//  i2c_write_ack  in   1            from engine; 1-cycle pulse
//  i2c_read_ack   in   1            from engine; 1-cycle pulse
//  wdata_in       out  8            to engine write byte
//  rdata          in   8            from engine read byte, valid on i2c_read_ack cycle
//  wr_dev_addr    out  8            {dev,1'b0}
//  wr_reg_addr    out  8            latched register address
//  rd_dev_addr    out  8            {dev,1'b1}
//  rd_reg_addr    out  8            latched register address (same value as wr_reg_addr)
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, all outputs 0 (rsp_rdata=8'h00, address/data regs 8'h00).
//  Reset asserted mid-transfer drops i2c_*_req on the next edge; no done/err is issued.
//  FSM: IDLE -> LOAD -> XFER -> DONE -> (GAP | IDLE).
//   IDLE: if any req_valid, pick first valid index at or after rr pointer (wrapping modulo
//         NUM_REQ); record grant index; go to LOAD. No valid: stay.
//   LOAD: latch req_rd/dev/reg/wdata of granted index into command regs; clear timeout cnt.
//   XFER: i2c_read_req = cmd_rd, i2c_write_req = !cmd_rd (exactly one high, never both).
//         Ack of matching type -> DONE; read ack also captures rdata into rsp_rdata.
//         Ack of the non-matching type is ignored. Timeout cnt == TIMEOUT_CYCLES-1 -> DONE
//         with abort flag set.
//   DONE: one cycle; req_done[grant]=1, req_err[grant]=abort; rr pointer = grant+1 (wrap).
//         Write (completed or aborted) -> GAP; read -> IDLE.
//   GAP:  count WR_GAP_CYCLES then IDLE; requests wait (not granted) during GAP.
//  Latency: req_valid sampled in IDLE at edge N -> engine req high from edge N+2; done pulse
//  one cycle after the ack cycle. Minimum read turnaround: ack+1 done, ack+2 back in IDLE.
//  Engine req deasserts the edge after ack (same edge DONE is entered).
//  Requester dropping req_valid after grant does not cancel the latched transfer.
//  req_valid of the just-served requester high in the IDLE cycle after DONE is granted only
//  if no other requester is valid (round-robin fairness).
//  Counters are 20-bit, saturate-free; they reset to 0 on every state entry.
// TESTING
//  1 single write: req0 wr dev=7'h50 reg=8'h01 data=8'h5A, ack after 10 clk -> wr_dev_addr=8'hA0,
//    wdata_in=8'h5A, done[0] 1 cycle, err=0, busy high for WR_GAP_CYCLES after done.
//  2 single read: req1 rd dev=7'h50 reg=8'h01, rdata=8'h3C with read_ack -> rd_dev_addr=8'hA1,
//    rsp_rdata=8'h3C at done[1], write_req never asserted.
//  3 contention: req0 and req1 valid same cycle, rr=0 -> grant 0 then 1; repeat with both
//    held -> order 0,1,0,1; no requester served twice in a row while other waits.
//  4 timeout: no ack (TIMEOUT_CYCLES=16 in bench) -> done+err pulse at XFER entry+17,
//    req dropped, GAP entered for write, IDLE directly for read.
//  5 reset mid-XFER: assert reset with write_req high -> write_req low next edge, no done,
//    all outputs 0, new request afterwards served from rr=0.
//  6 wrong-type ack: read_ack pulse during write XFER -> ignored; completion only on write_ack.

Source files
------------

// File: rtl/i2c_eeprom_arbiter_if.sv
// rtl/i2c_eeprom_arbiter_if.sv - requester and byte-engine signal bundle for the eeprom arbiter
interface i2c_eeprom_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_rd;
  logic [NUM_REQ*7-1:0] req_dev;
  logic [NUM_REQ*8-1:0] req_reg;
  logic [NUM_REQ*8-1:0] req_wdata;
  logic [NUM_REQ-1:0]   req_done;
  logic [NUM_REQ-1:0]   req_err;
  logic [7:0]           rsp_rdata;
  logic                 busy;
  logic                 i2c_write_req;
  logic                 i2c_read_req;
  logic                 i2c_write_ack;
  logic                 i2c_read_ack;
  logic [7:0]           wdata_in;
  logic [7:0]           rdata;
  logic [7:0]           wr_dev_addr;
  logic [7:0]           wr_reg_addr;
  logic [7:0]           rd_dev_addr;
  logic [7:0]           rd_reg_addr;

  modport slave (
    input  req_valid, req_rd, req_dev, req_reg, req_wdata,
    input  i2c_write_ack, i2c_read_ack, rdata,
    output req_done, req_err, rsp_rdata, busy,
    output i2c_write_req, i2c_read_req, wdata_in,
    output wr_dev_addr, wr_reg_addr, rd_dev_addr, rd_reg_addr
  );

  modport master (
    output req_valid, req_rd, req_dev, req_reg, req_wdata,
    output i2c_write_ack, i2c_read_ack, rdata,
    input  req_done, req_err, rsp_rdata, busy,
    input  i2c_write_req, i2c_read_req, wdata_in,
    input  wr_dev_addr, wr_reg_addr, rd_dev_addr, rd_reg_addr
  );
endinterface

// File: rtl/i2c_eeprom_arbiter.sv
// rtl/i2c_eeprom_arbiter.sv - round-robin arbiter sharing one i2c eeprom byte engine
module i2c_eeprom_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int WR_GAP_CYCLES  = 250000
) (
  input logic                clk,
  input logic                reset,
  i2c_eeprom_arbiter_if.slave bus
);
  localparam int          GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [19:0] GAP_LAST = 20'(WR_GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, XFER, DONE, GAP} state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] grant;
  logic [GW-1:0] pick;
  logic          pick_ok;
  logic          cmd_rd;
  logic          req_on;
  logic          ack_hit;
  logic [19:0]   cnt;

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    pick    = rr_ptr;
    pick_ok = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        pick    = GW'((int'(rr_ptr) + k) % NUM_REQ);
        pick_ok = 1'b1;
      end
    end
  end

  assign req_on  = bus.i2c_read_req | bus.i2c_write_req;
  assign ack_hit = (bus.i2c_read_req & bus.i2c_read_ack) | (bus.i2c_write_req & bus.i2c_write_ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      grant             <= '0;
      cmd_rd            <= 1'b0;
      cnt               <= '0;
      bus.req_done      <= '0;
      bus.req_err       <= '0;
      bus.rsp_rdata     <= 8'h00;
      bus.busy          <= 1'b0;
      bus.i2c_write_req <= 1'b0;
      bus.i2c_read_req  <= 1'b0;
      bus.wdata_in      <= 8'h00;
      bus.wr_dev_addr   <= 8'h00;
      bus.wr_reg_addr   <= 8'h00;
      bus.rd_dev_addr   <= 8'h00;
      bus.rd_reg_addr   <= 8'h00;
    end else begin
      bus.req_done <= '0;
      bus.req_err  <= '0;
      case (state)
        IDLE: begin
          if (pick_ok) begin
            grant    <= pick;
            bus.busy <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          cmd_rd          <= bus.req_rd[grant];
          bus.wr_dev_addr <= {bus.req_dev[int'(grant)*7 +: 7], 1'b0};
          bus.rd_dev_addr <= {bus.req_dev[int'(grant)*7 +: 7], 1'b1};
          bus.wr_reg_addr <= bus.req_reg[int'(grant)*8 +: 8];
          bus.rd_reg_addr <= bus.req_reg[int'(grant)*8 +: 8];
          bus.wdata_in    <= bus.req_wdata[int'(grant)*8 +: 8];
          cnt             <= '0;
          state           <= XFER;
        end
        XFER: begin
          // Acks only count while the matching engine request is actually up.
          if (ack_hit) begin
            if (bus.i2c_read_req) bus.rsp_rdata <= bus.rdata;
            bus.i2c_read_req    <= 1'b0;
            bus.i2c_write_req   <= 1'b0;
            bus.req_done[grant] <= 1'b1;
            cnt                 <= '0;
            state               <= DONE;
          end else if (req_on && cnt == TO_LAST) begin
            bus.i2c_read_req    <= 1'b0;
            bus.i2c_write_req   <= 1'b0;
            bus.req_done[grant] <= 1'b1;
            bus.req_err[grant]  <= 1'b1;
            cnt                 <= '0;
            state               <= DONE;
          end else begin
            bus.i2c_read_req  <= cmd_rd;
            bus.i2c_write_req <= !cmd_rd;
            if (req_on) cnt <= cnt + 20'd1;
          end
        end
        DONE: begin
          rr_ptr <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          cnt    <= '0;
          if (cmd_rd) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            state <= GAP;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt      <= '0;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_eeprom_arbiter.sv
// tb/tb_i2c_eeprom_arbiter.sv - self-checking bench for i2c_eeprom_arbiter
module tb_i2c_eeprom_arbiter;
  localparam int NR = 3;
  localparam int TO = 16;
  localparam int WG = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   rr_m = 0;
  logic [7:0] mem_m [int];

  always #5 clk = ~clk;

  i2c_eeprom_arbiter_if #(.NUM_REQ(NR)) bus ();

  i2c_eeprom_arbiter #(
    .NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .WR_GAP_CYCLES(WG)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  typedef struct {
    int         idx;
    bit         rd;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
    logic [7:0] rdat;
    int         dly;
    logic [7:0] exp_wdev;
    logic [7:0] exp_rdev;
  } vec_t;

  vec_t vt [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int idx, input bit rd, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [7:0] wd);
    bus.req_rd[idx]           = rd;
    bus.req_dev[idx*7 +: 7]   = dev;
    bus.req_reg[idx*8 +: 8]   = rg;
    bus.req_wdata[idx*8 +: 8] = wd;
    bus.req_valid[idx]        = 1'b1;
  endtask

  // Cycles from now until an engine request is visible.
  task automatic wait_req(output int n);
    n = 0;
    while (!(bus.i2c_read_req || bus.i2c_write_req) && n < 60) begin
      step();
      n++;
    end
    check("engine_req_seen", 32'(n < 60), 1);
  endtask

  // Plays the engine side for one transfer and checks the requester-facing result.
  task automatic serve(input int idx, input bit rd, input logic [7:0] rg, input logic [7:0] wd,
                       input logic [7:0] rdat, input int dly,
                       input logic [7:0] exp_wdev, input logic [7:0] exp_rdev);
    int n;
    wait_req(n);
    check("req_type", {30'd0, bus.i2c_read_req, bus.i2c_write_req}, {30'd0, rd, !rd});
    check("wr_dev_addr", bus.wr_dev_addr, exp_wdev);
    check("rd_dev_addr", bus.rd_dev_addr, exp_rdev);
    check("wr_reg_addr", bus.wr_reg_addr, rg);
    check("rd_reg_addr", bus.rd_reg_addr, rg);
    if (!rd) check("wdata_in", bus.wdata_in, wd);
    for (int i = 0; i < dly; i++) begin
      step();
      check("req_held", {29'd0, bus.i2c_read_req, bus.i2c_write_req, |bus.req_done},
            {29'd0, rd, !rd, 1'b0});
    end
    bus.rdata = rdat;
    if (rd) bus.i2c_read_ack = 1'b1;
    else    bus.i2c_write_ack = 1'b1;
    step();
    bus.i2c_read_ack  = 1'b0;
    bus.i2c_write_ack = 1'b0;
    bus.rdata         = 8'hEE;
    check("done", bus.req_done, 32'(1 << idx));
    check("err", bus.req_err, 0);
    check("req_drop", {bus.i2c_read_req, bus.i2c_write_req}, 0);
    if (rd) check("rsp_rdata", bus.rsp_rdata, rdat);
    bus.req_valid[idx] = 1'b0;
    rr_m = (idx + 1) % NR;
    step();
    check("done_width", bus.req_done, 0);
  endtask

  task automatic gap_count(input int exp);
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      step();
    end
    check("busy_after_done", n, exp);
  endtask

  // Round-robin choice from the model pointer over a set of held requests.
  function automatic int rr_pick(input logic [NR-1:0] pend);
    for (int k = 0; k < NR; k++)
      if (pend[(rr_m + k) % NR]) return (rr_m + k) % NR;
    return -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n, m;
    bit rd;
    logic [NR-1:0] pend;
    bit         q_rd  [NR];
    logic [6:0] q_dev [NR];
    logic [7:0] q_rg  [NR];
    logic [7:0] q_wd  [NR];
    logic [7:0] exp_r;

    vt[0] = '{0, 1'b0, 7'h50, 8'h01, 8'h5A, 8'h00, 10, 8'hA0, 8'hA1};
    vt[1] = '{1, 1'b1, 7'h50, 8'h01, 8'h00, 8'h3C, 3,  8'hA0, 8'hA1};
    vt[2] = '{2, 1'b0, 7'h7F, 8'hFF, 8'hFF, 8'h00, 0,  8'hFE, 8'hFF};
    vt[3] = '{0, 1'b1, 7'h00, 8'h00, 8'h00, 8'h81, 1,  8'h00, 8'h01};
    vt[4] = '{1, 1'b0, 7'h2A, 8'h80, 8'h00, 8'h00, 5,  8'h54, 8'h55};

    reset             = 1'b1;
    bus.req_valid     = '0;
    bus.req_rd        = '0;
    bus.req_dev       = '0;
    bus.req_reg       = '0;
    bus.req_wdata     = '0;
    bus.i2c_write_ack = 1'b0;
    bus.i2c_read_ack  = 1'b0;
    bus.rdata         = 8'hEE;
    repeat (3) step();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.req_done, 0);
    check("rst_reqs", {bus.i2c_read_req, bus.i2c_write_req}, 0);
    check("rst_rsp", bus.rsp_rdata, 0);
    check("rst_addr", {bus.wr_dev_addr, bus.rd_dev_addr, bus.wr_reg_addr, bus.wdata_in}, 0);
    reset = 1'b0;
    step();

    // Directed single transfers with an idle arbiter.
    for (int v = 0; v < 5; v++) begin
      set_req(vt[v].idx, vt[v].rd, vt[v].dev, vt[v].rg, vt[v].wd);
      wait_req(n);
      check("grant_latency", n, 3);
      serve(vt[v].idx, vt[v].rd, vt[v].rg, vt[v].wd, vt[v].rdat, vt[v].dly,
            vt[v].exp_wdev, vt[v].exp_rdev);
      gap_count(vt[v].rd ? 0 : WG);
    end

    // Timeouts: write on requester 1, then read on requester 0.
    for (int t = 0; t < 2; t++) begin
      rd = (t == 1);
      set_req(1 - t, rd, 7'h33, 8'h44, 8'h55);
      wait_req(n);
      m = 0;
      while (bus.req_done == 0 && m < 40) begin
        step();
        m++;
      end
      check("timeout_cycles", m, TO);
      check("timeout_done", bus.req_done, 32'(1 << (1 - t)));
      check("timeout_err", bus.req_err, 32'(1 << (1 - t)));
      check("timeout_drop", {bus.i2c_read_req, bus.i2c_write_req}, 0);
      bus.req_valid[1 - t] = 1'b0;
      rr_m = (1 - t + 1) % NR;
      step();
      check("err_width", bus.req_err, 0);
      gap_count(rd ? 0 : WG);
    end

    // Read ack during a write transfer must not complete it.
    set_req(0, 1'b0, 7'h21, 8'h09, 8'hC3);
    wait_req(n);
    bus.rdata        = 8'h99;
    bus.i2c_read_ack = 1'b1;
    step();
    bus.i2c_read_ack = 1'b0;
    check("wrong_ack_no_done", bus.req_done, 0);
    check("wrong_ack_req_kept", bus.i2c_write_req, 1);
    check("wrong_ack_rsp_kept", bus.rsp_rdata, 8'h81);
    serve(0, 1'b0, 8'h09, 8'hC3, 8'h00, 2, 8'h42, 8'h43);
    gap_count(WG);

    // Reset in the middle of a write; rr pointer was 1 before it.
    set_req(0, 1'b0, 7'h50, 8'h02, 8'h11);
    wait_req(n);
    reset = 1'b1;
    step();
    check("rst_mid_reqs", {bus.i2c_read_req, bus.i2c_write_req}, 0);
    check("rst_mid_done", {bus.req_done, bus.req_err}, 0);
    check("rst_mid_outs", {bus.busy, bus.wr_dev_addr, bus.wdata_in, bus.rsp_rdata}, 0);
    bus.req_valid = '0;
    step();
    reset = 1'b0;
    rr_m  = 0;

    // Contention between 0 and 1, each re-raising right after its own done.
    set_req(0, 1'b1, 7'h10, 8'h00, 8'h00);
    set_req(1, 1'b1, 7'h11, 8'h01, 8'h00);
    for (int s = 0; s < 4; s++) begin
      m = rr_pick(3'b011);
      check("rr_order", m, s % 2);
      serve(m, 1'b1, m == 0 ? 8'h00 : 8'h01, 8'h00, 8'(8'h60 + s), 1,
            m == 0 ? 8'h20 : 8'h22, m == 0 ? 8'h21 : 8'h23);
      if (s < 3) bus.req_valid[m] = 1'b1;
    end
    gap_count(0);

    // Randomised rounds: a random subset posts together and holds until served.
    for (int r = 0; r < 14; r++) begin
      pend = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) begin
        q_rd[i]  = 1'($urandom);
        q_dev[i] = 7'h50 + 7'($urandom_range(0, 1));
        q_rg[i]  = 8'($urandom_range(0, 3));
        q_wd[i]  = 8'($urandom);
        if (pend[i]) set_req(i, q_rd[i], q_dev[i], q_rg[i], q_wd[i]);
      end
      while (pend != 0) begin
        m = rr_pick(pend);
        if (q_rd[m]) begin
          if (mem_m.exists({q_dev[m], q_rg[m]})) exp_r = mem_m[{q_dev[m], q_rg[m]}];
          else exp_r = q_rg[m] ^ 8'hA5;
        end else begin
          exp_r = 8'h00;
          mem_m[{q_dev[m], q_rg[m]}] = q_wd[m];
        end
        serve(m, q_rd[m], q_rg[m], q_wd[m], exp_r, $urandom_range(0, 4),
              {q_dev[m], 1'b0}, {q_dev[m], 1'b1});
        gap_count((q_rd[m] || pend != (NR'(1) << m)) ? (q_rd[m] ? 0 : WG) : WG);
        pend[m] = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
